trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Sequences the CSR register file on trap entry (synchronous exception or interrupt) and MRET.
//  Arbitrates exception, MRET and interrupt requests, then drives the CSR write port one register
//  per cycle. Stalls and flushes the pipeline, then redirects the PC to mtvec (trap) or mepc (MRET).
//  Sits between the core control unit and the CSR register block; the sole CSR writer while busy.
// PARAMETERS
//  NUM_IRQ       8       number of level-sensitive interrupt lines (1..16)
//  ADDR_MSTATUS  12'h000 CSR address of mstatus
//  ADDR_MTVEC    12'h005 CSR address of mtvec
//  ADDR_MEPC     12'h041 CSR address of mepc
//  ADDR_MCAUSE   12'h042 CSR address of mcause
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  exc_valid    in   1        synchronous exception from the current instruction
//  exc_cause    in   5        exception code
//  exc_pc       in   32       PC of the faulting instruction
//  mret_valid   in   1        MRET in the current instruction
//  irq          in   NUM_IRQ  interrupt request lines, level-sensitive
//  irq_pc       in   32       PC of the next instruction to execute (saved on interrupt)
//  mstatus_mie  in   1        current mstatus bit 3 (MIE)
//  mstatus_mpie in   1        current mstatus bit 7 (MPIE)
//  csr_rdata    in   32       CSR read data for csr_addr
//  csr_w        out  1        CSR write enable
//  csr_addr     out  12       CSR address
//  csr_wdata    out  32       CSR write data
//  stall        out  1        hold fetch/decode; asserted combinationally in the accept cycle and while busy
//  flush        out  1        one-cycle pulse, concurrent with redirect
//  redirect     out  1        one-cycle pulse: load redirect_pc into the PC
//  redirect_pc  out  32       target PC, word aligned
// BEHAVIOUR
//  Reset: state=IDLE; csr_w=0, csr_addr=0, csr_wdata=0, stall=0, flush=0, redirect=0, redirect_pc=0.
//  Reset mid-sequence aborts immediately; no further CSR writes are issued.
//  Accept (IDLE only), priority exception > MRET > interrupt:
//   - exception: always taken.
//   - MRET: taken if no exception.
//   - interrupt: taken if any irq bit is set and mstatus_mie=1; the lowest index wins.
//  On accept, latch epc, cause, prev_ie and kind.
//   - exception: epc=exc_pc, cause={1'b0,26'b0,exc_cause}, prev_ie=mstatus_mie.
//   - interrupt: epc=irq_pc, cause={1'b1,26'b0,idx[4:0]}, prev_ie=1.
//   - MRET: latches mstatus_mpie only.
//  Requests arriving outside IDLE are ignored (pipeline is stalled); irq is sampled only in IDLE.
//  Trap FSM, accept at cycle T:
//   - T+1  W_EPC:    csr_w=1, addr=MEPC, wdata=epc.
//   - T+2  W_CAUSE:  csr_w=1, addr=MCAUSE, wdata=cause.
//   - T+3  W_STATUS: csr_w=1, addr=MSTATUS, wdata={24'b0, prev_ie, 3'b0, 1'b0, 3'b0} (MPIE=prev_ie, MIE=0).
//   - T+4  R_TVEC:   csr_w=0, addr=MTVEC; target <= {csr_rdata[31:2],2'b00} at end of cycle.
//   - T+5  REDIR:    redirect=1, flush=1, redirect_pc=target; return to IDLE.
//  MRET FSM, accept at cycle T:
//   - T+1  R_EPC:    addr=MEPC; target <= {csr_rdata[31:2],2'b00}.
//   - T+2  W_MSTAT:  csr_w=1, addr=MSTATUS, wdata={24'b0,1'b1,3'b0,latched_mpie,3'b0}.
//   - T+3  REDIR:    as above.
//  stall is 1 from the accept cycle through REDIR inclusive, then 0.
//   - Back-to-back: a new request can be accepted in the cycle after REDIR.
//  In IDLE: csr_w=0, csr_addr=0, csr_wdata=0; the core owns the CSR port.
//  Outputs other than stall are registered; redirect_pc holds its value until the next REDIR.
// TESTING
//  1. exc_valid=1, cause=2, exc_pc=0x100, mtvec=0x204, MIE=1
//     -> writes mepc=0x100, mcause=0x2, mstatus=0x80; redirect at T+5 to 0x204.
//  2. irq=8'b0010_0100, MIE=1, irq_pc=0x40
//     -> mcause=0x8000_0002, mepc=0x40, mstatus=0x80; redirect to mtvec.
//  3. irq=0x01, MIE=0 for 10 cycles
//     -> no accept, stall=0, csr_w=0 throughout.
//  4. exc_valid, mret_valid and irq all high in the same cycle
//     -> exception path taken; MRET and irq ignored until IDLE.
//  5. mret_valid=1, mepc=0x123, MPIE=1
//     -> mstatus write 0x88, redirect at T+3 to 0x120.
//  6. rst_n low during W_CAUSE
//     -> all outputs 0 immediately, no W_STATUS write, IDLE after release.

Source files
------------

// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
//   Sequences CSR updates on trap entry (synchronous exception or interrupt)
//   and on MRET. Arbitrates the three request sources, walks the CSR write
//   port one register per cycle, then pulses redirect/flush toward mtvec
//   (trap) or mepc (MRET). While busy it is the only CSR writer and holds the
//   pipeline stalled.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   exc_valid      synchronous exception request; exc_cause / exc_pc describe it
//   mret_valid     MRET request
//   irq            level-sensitive interrupt lines (lowest index wins)
//   irq_pc         PC saved to mepc when an interrupt is taken
//   mstatus_mie    current mstatus.MIE
//   mstatus_mpie   current mstatus.MPIE
//   csr_rdata      CSR read data for csr_addr
//   csr_w          CSR write enable            (registered)
//   csr_addr       CSR address                 (registered)
//   csr_wdata      CSR write data              (registered)
//   stall          hold fetch/decode; combinational in the accept cycle
//   flush          one-cycle pulse alongside redirect (registered)
//   redirect       one-cycle pulse: load redirect_pc into the PC (registered)
//   redirect_pc    word-aligned target; holds until the next redirect
// -----------------------------------------------------------------------------
module trap_sequencer #(
  parameter int unsigned NUM_IRQ      = 8,
  parameter logic [11:0] ADDR_MSTATUS = 12'h000,
  parameter logic [11:0] ADDR_MTVEC   = 12'h005,
  parameter logic [11:0] ADDR_MEPC    = 12'h041,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h042
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               exc_valid,
  input  logic [4:0]         exc_cause,
  input  logic [31:0]        exc_pc,
  input  logic               mret_valid,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        irq_pc,
  input  logic               mstatus_mie,
  input  logic               mstatus_mpie,
  input  logic [31:0]        csr_rdata,
  output logic               csr_w,
  output logic [11:0]        csr_addr,
  output logic [31:0]        csr_wdata,
  output logic               stall,
  output logic               flush,
  output logic               redirect,
  output logic [31:0]        redirect_pc
);

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_STATUS,
    R_TVEC,
    R_EPC,
    W_MSTAT,
    REDIR
  } state_t;

  state_t      state;
  logic [31:0] cause;
  logic        prev_ie;
  logic        mpie_l;
  logic [31:0] target;

  logic        irq_any;
  logic [4:0]  irq_idx;
  logic        idle;
  logic        take_exc;
  logic        take_mret;
  logic        take_irq;
  logic [31:0] rdata_aligned;

  // Lowest-index pending interrupt: scan downward so the last hit is the lowest.
  always_comb begin
    irq_any = 1'b0;
    irq_idx = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (irq[i-1]) begin
        irq_any = 1'b1;
        irq_idx = 5'(i - 1);
      end
    end
  end

  // Accept only in IDLE and never while reset is held, so stall reads 0 in reset.
  assign idle      = rst_n && (state == IDLE);
  assign take_exc  = idle && exc_valid;
  assign take_mret = idle && !exc_valid && mret_valid;
  assign take_irq  = idle && !exc_valid && !mret_valid && irq_any && mstatus_mie;

  assign stall = (state != IDLE) || take_exc || take_mret || take_irq;

  assign rdata_aligned = csr_rdata & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cause       <= '0;
      prev_ie     <= 1'b0;
      mpie_l      <= 1'b0;
      target      <= '0;
      csr_w       <= 1'b0;
      csr_addr    <= '0;
      csr_wdata   <= '0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush    <= 1'b0;
      redirect <= 1'b0;
      case (state)
        IDLE: begin
          // The saved PC goes straight onto the write port for the W_EPC cycle,
          // so it needs no separate holding register.
          if (take_exc) begin
            cause     <= {27'b0, exc_cause};
            prev_ie   <= mstatus_mie;
            state     <= W_EPC;
            csr_w     <= 1'b1;
            csr_addr  <= ADDR_MEPC;
            csr_wdata <= exc_pc;
          end else if (take_mret) begin
            mpie_l    <= mstatus_mpie;
            state     <= R_EPC;
            csr_w     <= 1'b0;
            csr_addr  <= ADDR_MEPC;
            csr_wdata <= '0;
          end else if (take_irq) begin
            cause     <= {1'b1, 26'b0, irq_idx};
            prev_ie   <= 1'b1;
            state     <= W_EPC;
            csr_w     <= 1'b1;
            csr_addr  <= ADDR_MEPC;
            csr_wdata <= irq_pc;
          end else begin
            csr_w     <= 1'b0;
            csr_addr  <= '0;
            csr_wdata <= '0;
          end
        end

        W_EPC: begin
          state     <= W_CAUSE;
          csr_w     <= 1'b1;
          csr_addr  <= ADDR_MCAUSE;
          csr_wdata <= cause;
        end

        W_CAUSE: begin
          // MPIE (bit 7) takes the prior interrupt enable; MIE (bit 3) cleared.
          state     <= W_STATUS;
          csr_w     <= 1'b1;
          csr_addr  <= ADDR_MSTATUS;
          csr_wdata <= {24'b0, prev_ie, 7'b0};
        end

        W_STATUS: begin
          state     <= R_TVEC;
          csr_w     <= 1'b0;
          csr_addr  <= ADDR_MTVEC;
          csr_wdata <= '0;
        end

        R_TVEC: begin
          // mtvec is on csr_rdata this cycle; load it straight into the target.
          target      <= rdata_aligned;
          redirect_pc <= rdata_aligned;
          redirect    <= 1'b1;
          flush       <= 1'b1;
          state       <= REDIR;
          csr_w       <= 1'b0;
          csr_addr    <= '0;
          csr_wdata   <= '0;
        end

        R_EPC: begin
          target    <= rdata_aligned;
          state     <= W_MSTAT;
          csr_w     <= 1'b1;
          csr_addr  <= ADDR_MSTATUS;
          csr_wdata <= {24'b0, 1'b1, 3'b0, mpie_l, 3'b0};
        end

        W_MSTAT: begin
          redirect_pc <= target;
          redirect    <= 1'b1;
          flush       <= 1'b1;
          state       <= REDIR;
          csr_w       <= 1'b0;
          csr_addr    <= '0;
          csr_wdata   <= '0;
        end

        REDIR: begin
          state     <= IDLE;
          csr_w     <= 1'b0;
          csr_addr  <= '0;
          csr_wdata <= '0;
        end

        default: begin
          state     <= IDLE;
          csr_w     <= 1'b0;
          csr_addr  <= '0;
          csr_wdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trap_sequencer
//   Directed scenarios followed by randomized traffic. A transaction-level
//   model turns each accepted request into the list of per-cycle port values
//   it must produce; a small CSR file answers csr_rdata and absorbs writes.
// -----------------------------------------------------------------------------
module tb_trap_sequencer;

  localparam int          NUM_IRQ   = 8;
  localparam logic [11:0] A_MSTATUS = 12'h000;
  localparam logic [11:0] A_MTVEC   = 12'h005;
  localparam logic [11:0] A_MEPC    = 12'h041;
  localparam logic [11:0] A_MCAUSE  = 12'h042;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               exc_valid;
  logic [4:0]         exc_cause;
  logic [31:0]        exc_pc;
  logic               mret_valid;
  logic [NUM_IRQ-1:0] irq;
  logic [31:0]        irq_pc;
  logic               mstatus_mie;
  logic               mstatus_mpie;
  logic [31:0]        csr_rdata;
  logic               csr_w;
  logic [11:0]        csr_addr;
  logic [31:0]        csr_wdata;
  logic               stall;
  logic               flush;
  logic               redirect;
  logic [31:0]        redirect_pc;

  always #5 clk = ~clk;

  trap_sequencer #(
    .NUM_IRQ     (NUM_IRQ),
    .ADDR_MSTATUS(A_MSTATUS),
    .ADDR_MTVEC  (A_MTVEC),
    .ADDR_MEPC   (A_MEPC),
    .ADDR_MCAUSE (A_MCAUSE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .exc_valid   (exc_valid),
    .exc_cause   (exc_cause),
    .exc_pc      (exc_pc),
    .mret_valid  (mret_valid),
    .irq         (irq),
    .irq_pc      (irq_pc),
    .mstatus_mie (mstatus_mie),
    .mstatus_mpie(mstatus_mpie),
    .csr_rdata   (csr_rdata),
    .csr_w       (csr_w),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  // CSR file seen by the DUT
  logic [31:0] f_mstatus, f_mtvec, f_mepc, f_mcause;

  always_comb begin
    case (csr_addr)
      A_MSTATUS: csr_rdata = f_mstatus;
      A_MTVEC:   csr_rdata = f_mtvec;
      A_MEPC:    csr_rdata = f_mepc;
      A_MCAUSE:  csr_rdata = f_mcause;
      default:   csr_rdata = 32'h0;
    endcase
  end

  // Reference model: one record per expected busy cycle
  typedef struct {
    bit        w;
    bit        ca;
    bit [11:0] addr;
    bit        cd;
    bit [31:0] wdata;
    bit        rd;
    bit        redir;
  } rec_t;

  rec_t        q[$];
  logic [31:0] m_mepc;
  logic [31:0] m_target;
  logic [31:0] exp_rpc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic rec_t mk(bit w, bit ca, bit [11:0] a, bit cd, bit [31:0] d, bit rd, bit redir);
    rec_t r;
    r.w = w; r.ca = ca; r.addr = a; r.cd = cd; r.wdata = d; r.rd = rd; r.redir = redir;
    return r;
  endfunction

  task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause, input bit pie);
    q.push_back(mk(1, 1, A_MEPC,    1, epc,   0, 0));
    q.push_back(mk(1, 1, A_MCAUSE,  1, cause, 0, 0));
    q.push_back(mk(1, 1, A_MSTATUS, 1, pie ? 32'h80 : 32'h0, 0, 0));
    q.push_back(mk(0, 1, A_MTVEC,   0, 0,     1, 0));
    q.push_back(mk(0, 0, 12'h0,     0, 0,     0, 1));
  endtask

  task automatic model_cycle();
    rec_t r;
    int   idx;
    bit   acc;
    if (q.size() == 0) begin
      idx = -1;
      for (int i = NUM_IRQ - 1; i >= 0; i--) if (irq[i]) idx = i;
      acc = exc_valid || mret_valid || (idx >= 0 && mstatus_mie);
      check("idle_stall",    32'(stall),    32'(acc));
      check("idle_csr_w",    32'(csr_w),    32'h0);
      check("idle_csr_addr", 32'(csr_addr), 32'h0);
      check("idle_wdata",    csr_wdata,     32'h0);
      check("idle_redirect", 32'(redirect), 32'h0);
      check("idle_flush",    32'(flush),    32'h0);
      if (exc_valid) begin
        push_trap(exc_pc, {27'b0, exc_cause}, mstatus_mie);
      end else if (mret_valid) begin
        q.push_back(mk(0, 1, A_MEPC,    0, 0, 1, 0));
        q.push_back(mk(1, 1, A_MSTATUS, 1, 32'h80 | (mstatus_mpie ? 32'h8 : 32'h0), 0, 0));
        q.push_back(mk(0, 0, 12'h0,     0, 0, 0, 1));
      end else if (idx >= 0 && mstatus_mie) begin
        push_trap(irq_pc, 32'h8000_0000 | 32'(idx), 1'b1);
      end
    end else begin
      r = q.pop_front();
      check("busy_stall", 32'(stall), 32'h1);
      check("busy_csr_w", 32'(csr_w), 32'(r.w));
      if (r.ca) check("busy_csr_addr", 32'(csr_addr), 32'(r.addr));
      if (r.cd) check("busy_wdata", csr_wdata, r.wdata);
      check("busy_redirect", 32'(redirect), 32'(r.redir));
      check("busy_flush",    32'(flush),    32'(r.redir));
      if (r.w && r.addr == A_MEPC) m_mepc = r.wdata;
      if (r.rd) m_target = ((r.addr == A_MTVEC) ? f_mtvec : m_mepc) & 32'hFFFF_FFFC;
      if (r.redir) exp_rpc = m_target;
    end
    check("redirect_pc", redirect_pc, exp_rpc);
  endtask

  // Entered 1 time unit after a rising edge with inputs already applied.
  task automatic run_cycle();
    logic        pw;
    logic [11:0] pa;
    logic [31:0] pd;
    #3;
    model_cycle();
    pw = csr_w; pa = csr_addr; pd = csr_wdata;
    @(posedge clk);
    #1;
    if (pw) begin
      case (pa)
        A_MSTATUS: f_mstatus = pd;
        A_MTVEC:   f_mtvec   = pd;
        A_MEPC:    f_mepc    = pd;
        A_MCAUSE:  f_mcause  = pd;
        default:   ;
      endcase
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic clear_inputs();
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; mret_valid = 1'b0;
    irq = '0; irq_pc = '0; mstatus_mie = 1'b0; mstatus_mpie = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},    32'(stall),    32'h0);
    check({tag, "_csr_w"},    32'(csr_w),    32'h0);
    check({tag, "_csr_addr"}, 32'(csr_addr), 32'h0);
    check({tag, "_wdata"},    csr_wdata,     32'h0);
    check({tag, "_redirect"}, 32'(redirect), 32'h0);
    check({tag, "_flush"},    32'(flush),    32'h0);
    check({tag, "_rpc"},      redirect_pc,   32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    f_mstatus = '0; f_mtvec = 32'h204; f_mepc = '0; f_mcause = '0;
    m_mepc = '0; m_target = '0; exp_rpc = '0;

    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_n(2);

    // 1: exception, redirect to mtvec
    exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h100; mstatus_mie = 1'b1;
    run_cycle();
    clear_inputs();
    run_n(6);
    check("t1_mepc",    f_mepc,      32'h100);
    check("t1_mcause",  f_mcause,    32'h2);
    check("t1_mstatus", f_mstatus,   32'h80);
    check("t1_rpc",     redirect_pc, 32'h204);

    // 2: interrupt, lowest pending index wins
    irq = 8'b0010_0100; mstatus_mie = 1'b1; irq_pc = 32'h40;
    run_cycle();
    clear_inputs();
    run_n(6);
    check("t2_mcause",  f_mcause,  32'h8000_0002);
    check("t2_mepc",    f_mepc,    32'h40);
    check("t2_mstatus", f_mstatus, 32'h80);

    // 3: masked interrupt never accepted
    irq = 8'h01; mstatus_mie = 1'b0;
    run_n(10);
    clear_inputs();

    // 4: simultaneous requests; MRET and irq held high through the trap
    exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h300;
    mret_valid = 1'b1; irq = 8'hFF; mstatus_mie = 1'b1;
    run_cycle();
    exc_valid = 1'b0;
    run_n(5);
    clear_inputs();
    run_n(2);
    check("t4_mcause", f_mcause, 32'h5);
    check("t4_mepc",   f_mepc,   32'h300);

    // 5: MRET with unaligned mepc
    f_mepc = 32'h123; m_mepc = 32'h123;
    mret_valid = 1'b1; mstatus_mpie = 1'b1;
    run_cycle();
    clear_inputs();
    run_n(4);
    check("t5_mstatus", f_mstatus,   32'h88);
    check("t5_rpc",     redirect_pc, 32'h120);

    // 6: reset during W_CAUSE aborts the sequence
    f_mstatus = 32'h0;
    exc_valid = 1'b1; exc_cause = 5'd7; exc_pc = 32'h500; mstatus_mie = 1'b1;
    run_cycle();
    clear_inputs();
    run_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    q.delete();
    exp_rpc = '0;
    m_target = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_n(6);
    check("t6_no_status", f_mstatus, 32'h0);
    check("t6_mepc",      f_mepc,    32'h500);

    // Randomized traffic, including requests arriving while busy
    for (int n = 0; n < 3000; n++) begin
      if (q.size() == 0 && $urandom_range(0, 15) == 0) begin
        f_mtvec = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          f_mepc = $urandom;
          m_mepc = f_mepc;
        end
      end
      exc_valid    = ($urandom_range(0, 9) == 0);
      exc_cause    = 5'($urandom);
      exc_pc       = $urandom;
      mret_valid   = ($urandom_range(0, 9) == 0);
      irq          = ($urandom_range(0, 3) == 0) ? NUM_IRQ'($urandom) : '0;
      irq_pc       = $urandom;
      mstatus_mie  = 1'($urandom);
      mstatus_mpie = 1'($urandom);
      run_cycle();
    end
    clear_inputs();
    run_n(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
